// File: rtl/mux8_pkg.sv
// Shared definitions for the 8-way mux scan sampler.
//   scan_state_t : controller states (IDLE, SCAN, HOLD)
//   NUM_CH       : number of mux channels scanned per word
//   SEL_W        : width of the channel select bus
package mux8_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } scan_state_t;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

endpackage

// File: rtl/mux8_scan_sampler.sv
// Sequential front-end for an 8-way 1-bit multiplexer.
// Steps the mux select through channels 0..7, holds each channel for SETTLE
// cycles, samples the mux output on the last cycle of each hold, and presents
// the assembled 8-bit word downstream with a valid/ready handshake.
//
// Parameters:
//   SETTLE   cycles each channel is held before it is sampled (1..16)
// Ports:
//   clk      clock, all state changes on the rising edge
//   rst_n    asynchronous active-low reset
//   start    scan request, honoured in IDLE, or in HOLD together with ready
//   sel      channel select to the mux (registered)
//   mux_out  1-bit mux output
//   data     assembled word, data[k] = mux_out sampled while sel==k (registered)
//   valid    data complete and stable (registered)
//   ready    downstream accept; transfer occurs on valid && ready
//   busy     high while scanning or holding a word (registered)
module mux8_scan_sampler
  import mux8_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_out,
  output logic [NUM_CH-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              busy
);

  if (SETTLE < 1 || SETTLE > 16) begin : g_bad_settle
    $error("mux8_scan_sampler: SETTLE must be in 1..16");
  end

  localparam int               CNT_W    = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

  scan_state_t       state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] data_q;
  logic              valid_q;
  logic              busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            sel_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        SCAN: begin
          if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            // Last settle cycle of this channel: capture and move on.
            data_q[sel_q] <= mux_out;
            cnt_q         <= '0;
            if (sel_q == SEL_LAST) begin
              // Select returns to 0 only on the way out of the scan.
              sel_q   <= '0;
              state_q <= HOLD;
              valid_q <= 1'b1;
            end else begin
              sel_q <= sel_q + 1'b1;
            end
          end
        end

        HOLD: begin
          if (ready) begin
            valid_q <= 1'b0;
            if (start) begin
              // Chain straight into the next scan, busy stays high.
              state_q <= SCAN;
              sel_q   <= '0;
              cnt_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel   = sel_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux8_scan_sampler.sv
// Bench for mux8_scan_sampler: two lanes, SETTLE=1 and SETTLE=3, each with its
// own DUT, a time-based reference model, a per-cycle compare process and a
// directed-then-random scenario.
module tb_mux8_scan_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit lane_done [2];

  task automatic chk(input int lane, input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got %0h, required %0h (t=%0t)", lane, name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int         S         = (gi == 0) ? 1 : 3;
    localparam logic [7:0] FIRST_PAT = (gi == 0) ? 8'hA5 : 8'h3C;

    logic       rst_n;
    logic       start;
    logic       mux_out;
    logic       ready;
    logic [2:0] sel;
    logic [7:0] data;
    logic       valid;
    logic       busy;

    // Reference model: mode 0 idle, 1 scanning, 2 holding a word.
    // m_j counts edges since the accepting edge; edge j samples channel j/S-1
    // whenever j is a multiple of S.
    int         m_mode = 0;
    int         m_j    = 0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] pat    = 8'h00;
    bit         checking = 1'b0;

    mux8_scan_sampler #(.SETTLE(S)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .sel     (sel),
      .mux_out (mux_out),
      .data    (data),
      .valid   (valid),
      .ready   (ready),
      .busy    (busy)
    );

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_mode <= 0;
        m_j    <= 0;
        m_data <= 8'h00;
      end else begin
        case (m_mode)
          0: if (start) begin
               m_mode <= 1;
               m_j    <= 0;
             end
          1: begin
               m_j <= m_j + 1;
               if (((m_j + 1) % S) == 0) m_data[(m_j + 1) / S - 1] <= mux_out;
               if (m_j + 1 == 8 * S) m_mode <= 2;
             end
          default: if (ready) begin
               m_mode <= start ? 1 : 0;
               m_j    <= 0;
             end
        endcase
      end
    end

    always @(posedge clk) begin
      int es;
      #1;
      if (checking && rst_n) begin
        es = (m_mode == 1) ? m_j / S : 0;
        chk(gi, "sel", 32'(sel), es);
        chk(gi, "data", 32'(data), 32'(m_data));
        chk(gi, "valid", 32'(valid), (m_mode == 2) ? 1 : 0);
        chk(gi, "busy", 32'(busy), (m_mode != 0) ? 1 : 0);
      end
    end

    // Advance to the next falling edge and present the mux output: the
    // pattern bit on the cycle before a sample edge, noise otherwise.
    task automatic tick();
      @(negedge clk);
      if (m_mode == 1 && ((m_j + 1) % S) == 0) mux_out = pat[sel];
      else mux_out = 1'($urandom);
    endtask

    task automatic wait_valid(output int n);
      n = 0;
      while (!valid && n < 400) begin
        tick();
        n++;
      end
      if (n >= 400) chk(gi, "valid_timeout", 32'(valid), 1);
    endtask

    initial begin
      int n;
      int nv;
      rst_n = 1'b0; start = 1'b0; ready = 1'b0; mux_out = 1'b0;
      repeat (3) tick();
      chk(gi, "rst_sel", 32'(sel), 0);
      chk(gi, "rst_data", 32'(data), 0);
      chk(gi, "rst_valid", 32'(valid), 0);
      chk(gi, "rst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      checking = 1'b1;
      tick();

      // Basic scan / settle stretch with noise between samples.
      pat = FIRST_PAT; ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid(n);
      chk(gi, "latency", n, 8 * S);
      chk(gi, "first_word", 32'(data), 32'(FIRST_PAT));
      tick();
      chk(gi, "post_hs_valid", 32'(valid), 0);
      chk(gi, "post_hs_busy", 32'(busy), 0);

      // Backpressure: no transfer for 20 cycles while start/mux_out toggle.
      ready = 1'b0; pat = 8'($urandom); start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid(n);
      repeat (20) begin
        start = 1'($urandom);
        tick();
      end
      chk(gi, "bp_valid", 32'(valid), 1);
      chk(gi, "bp_data", 32'(data), 32'(pat));
      start = 1'b0; ready = 1'b1;
      tick();
      chk(gi, "bp_release_valid", 32'(valid), 0);
      chk(gi, "bp_release_busy", 32'(busy), 0);

      // Back-to-back: 8'hFF then 8'h00 with start and ready held high.
      pat = 8'hFF; start = 1'b1;
      tick();
      wait_valid(n);
      chk(gi, "b2b_first", 32'(data), 32'hFF);
      pat = 8'h00;
      tick();
      n = 1;
      while (!valid && n < 400) begin
        tick();
        n++;
      end
      chk(gi, "b2b_interval", n, 8 * S + 1);
      chk(gi, "b2b_second", 32'(data), 32'h00);
      start = 1'b0;
      tick();
      chk(gi, "b2b_idle_busy", 32'(busy), 0);

      // Start pulsed mid-scan at sel==2 must not restart or add a word.
      pat = 8'($urandom) | 8'h01; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(m_mode == 1 && m_j / S == 2) && n < 100) begin
        tick();
        n++;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      nv = 0;
      repeat (16 * S + 8) begin
        tick();
        if (valid) nv++;
      end
      chk(gi, "ignored_start_words", nv, 1);
      chk(gi, "ignored_start_data", 32'(data), 32'(pat));

      // Asynchronous reset while sel==4.
      pat = 8'($urandom); start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(m_mode == 1 && m_j / S == 4) && n < 100) begin
        tick();
        n++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk(gi, "arst_sel", 32'(sel), 0);
      chk(gi, "arst_data", 32'(data), 0);
      chk(gi, "arst_valid", 32'(valid), 0);
      chk(gi, "arst_busy", 32'(busy), 0);
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk(gi, "post_arst_busy", 32'(busy), 0);
      chk(gi, "post_arst_sel", 32'(sel), 0);

      // Random traffic against the model.
      repeat (1500) begin
        if (m_mode == 0) pat = 8'($urandom);
        start = ($urandom_range(0, 2) == 0);
        ready = ($urandom_range(0, 1) == 1);
        tick();
      end
      start = 1'b0;
      tick();
      lane_done[gi] = 1'b1;
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (!(lane_done[0] && lane_done[1]) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) begin
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: lanes finished %0d%0d, required 11", lane_done[0], lane_done[1]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
